shared_unit_sched: RTL

- Round-robin scheduler that time-multiplexes one shared single-function unit among N_REQ requesters.
- The shared unit is an a_mod/b_mod-style leaf with UNIT_LAT-cycle latency.
- Sits in the top level between the requesting logic and the one physical unit instance, replacing per-requester duplicate instances.
- Owns request/grant handshake, operand steering, latency counting and response return.

---
 rtl/shared_unit_sched_pkg.sv | 14 +
 rtl/shared_unit_sched_rr_pick.sv | 36 +++
 rtl/shared_unit_sched.sv | 107 ++++++++++
 3 files changed

// File: rtl/shared_unit_sched_pkg.sv
// Shared types and helpers for the round-robin shared-unit scheduler.
package shared_unit_sched_pkg;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_e;

  // Bit width needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/shared_unit_sched_rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr_i, wrapping.
// Zero latency; any_o low means no winner and win_oh_o is all zero.
module shared_unit_sched_rr_pick
  import shared_unit_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  win_oh_o,
  output logic [PW-1:0] win_idx_o,
  output logic          any_o
);

  logic found;
  int   j;

  always_comb begin
    found     = 1'b0;
    win_idx_o = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[PW'(j)]) begin
        found     = 1'b1;
        win_idx_o = PW'(j);
      end
    end
  end

  assign any_o    = found;
  assign win_oh_o = found ? (N'(1) << win_idx_o) : '0;

endmodule

// File: rtl/shared_unit_sched.sv
// Time-multiplexes one shared UNIT_LAT-cycle unit among N_REQ requesters, round-robin.
// Grant one edge after a request is seen in IDLE; result UNIT_LAT edges after grant; requests wait while busy.
module shared_unit_sched
  import shared_unit_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int W        = 1,
  parameter int UNIT_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic [W-1:0]       unit_in,
  input  logic [W-1:0]       unit_out,
  output logic               busy
);

  localparam int PW = clog2(N_REQ);
  localparam int CW = clog2(UNIT_LAT);

  generate
    if (UNIT_LAT < 1 || N_REQ < 2 || N_REQ > 16) begin : g_bad_param
      $error("shared_unit_sched: UNIT_LAT must be >= 1 and N_REQ in 2..16");
    end
  endgenerate

  state_e           state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    sel_q;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [W-1:0]     rsp_data_q;
  logic [W-1:0]     unit_in_q;
  logic             busy_q;

  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic [W-1:0]     pick_opnd;
  logic [PW-1:0]    ptr_d;

  shared_unit_sched_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  assign pick_opnd = req_data[int'(pick_idx)*W +: W];
  // The requester just served drops to lowest priority for the next round.
  assign ptr_d     = (sel_q == PW'(N_REQ-1)) ? '0 : sel_q + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      unit_in_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= '0;
          gnt_q       <= pick_oh;
          if (pick_any) begin
            sel_q     <= pick_idx;
            unit_in_q <= pick_opnd;
            cnt_q     <= CW'(UNIT_LAT-1);
            busy_q    <= 1'b1;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          gnt_q <= '0;
          if (cnt_q != '0) begin
            cnt_q       <= cnt_q - CW'(1);
            rsp_valid_q <= '0;
          end else begin
            rsp_data_q  <= unit_out;
            rsp_valid_q <= N_REQ'(1) << sel_q;
            ptr_q       <= ptr_d;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign unit_in   = unit_in_q;
  assign busy      = busy_q;

endmodule
